// File: rtl/crc_write_framer.sv
// Write-data framer: groups 8 accepted two-UI words into a burst and, when write CRC
// is enabled, appends the generator's CRC word. The output stream is registered once.
module crc_write_framer #(
  parameter int N = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_crc_mode,
  input  logic           i_wr_valid,
  output logic           o_wr_ready,
  input  logic [2*N-1:0] i_wr_data,
  output logic           o_crc_en,
  output logic [2*N-1:0] o_crc_in_data,
  input  logic [2*N-1:0] i_crc_code,
  output logic           o_dq_valid,
  output logic [2*N-1:0] o_dq_data,
  output logic           o_dq_is_crc,
  output logic           o_burst_done
);

  localparam int W = 2 * N;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] CRC  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         dq_valid_q, dq_valid_d;
  logic [W-1:0] dq_data_q, dq_data_d;
  logic         dq_is_crc_q, dq_is_crc_d;
  logic         burst_done_q, burst_done_d;
  logic         accept;

  // Gating with i_reset keeps the framer from accepting or pulsing the generator in reset.
  assign o_wr_ready    = i_reset & (state_q != CRC);
  assign accept        = i_wr_valid & o_wr_ready;
  assign o_crc_en      = i_reset & (accept | (state_q == CRC));
  assign o_crc_in_data = i_wr_data;

  assign o_dq_valid   = dq_valid_q;
  assign o_dq_data    = dq_data_q;
  assign o_dq_is_crc  = dq_is_crc_q;
  assign o_burst_done = burst_done_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    dq_valid_d   = 1'b0;
    dq_data_d    = dq_data_q;
    dq_is_crc_d  = 1'b0;
    burst_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = i_crc_mode;
          cnt_d   = 3'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (cnt_q == 3'd7) begin
            cnt_d        = 3'd0;
            state_d      = mode_q ? CRC : IDLE;
            burst_done_d = ~mode_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      CRC: begin
        state_d      = IDLE;
        dq_valid_d   = 1'b1;
        dq_data_d    = i_crc_code;
        dq_is_crc_d  = 1'b1;
        burst_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      dq_valid_d = 1'b1;
      dq_data_d  = i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      mode_q       <= 1'b0;
      dq_valid_q   <= 1'b0;
      dq_data_q    <= '0;
      dq_is_crc_q  <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      dq_valid_q   <= dq_valid_d;
      dq_data_q    <= dq_data_d;
      dq_is_crc_q  <= dq_is_crc_d;
      burst_done_q <= burst_done_d;
    end
  end

endmodule

// File: doc/crc_write_framer.md
CRC_WRITE_FRAMER -- requirements
Module: crc_write_framer

Interface
REQ-001 Parameter: N, default 16; DQ width of the device (4, 8 or 16); each data word carries two unit intervals (UIs), so data width is 2N.
REQ-002 i_clk  input  1  clock; all logic on rising edge.
REQ-003 i_reset  input  1  synchronous, active-low reset.
REQ-004 i_crc_mode  input  1  1 = write CRC enabled (burst plus CRC word); 0 = CRC disabled.
REQ-005 i_wr_valid  input  1  upstream write-data word valid.
REQ-006 o_wr_ready  output  1  framer can accept a word this cycle.
REQ-007 i_wr_data  input  2N  write-data word (two UIs).
REQ-008 o_crc_en  output  1  enable to the CRC generator.
REQ-009 o_crc_in_data  output  2N  data to the CRC generator.
REQ-010 i_crc_code  input  2N  CRC result from the generator; valid in the CRC cycle only.
REQ-011 o_dq_valid  output  1  output word valid.
REQ-012 o_dq_data  output  2N  framed output word (data or CRC).
REQ-013 o_dq_is_crc  output  1  the current output word is the CRC word.
REQ-014 o_burst_done  output  1  one-cycle pulse with the last output word of a burst.

Function
REQ-015 Accept: a word is accepted in any cycle where i_wr_valid=1 and o_wr_ready=1.
REQ-016 Burst length: a burst is exactly 8 accepted words (BL16).
REQ-017 States: IDLE, DATA and CRC; a 3-bit beat counter cnt counts accepted words.
REQ-018 IDLE (cnt=0): o_wr_ready=1; on accept, latch i_crc_mode into mode_q, set cnt=1 and go to DATA.
REQ-019 DATA: o_wr_ready=1; each accept increments cnt.
REQ-020 DATA, 8th accept: cnt wraps to 0; go to CRC if mode_q=1, else go to IDLE.
REQ-021 Gaps: cycles with i_wr_valid=0 inside a burst hold cnt and state; the burst is not aborted.
REQ-022 CRC state: lasts exactly one cycle with o_wr_ready=0; o_crc_en=1 and i_crc_code is sampled; next state is IDLE.
REQ-023 o_crc_en = (accept) OR (state=CRC); combinational.
REQ-024 o_crc_in_data = i_wr_data; combinational, unregistered.
REQ-025 Output pipeline: registered with 1-cycle latency.
  - Accepted word in cycle t: o_dq_valid=1, o_dq_data=i_wr_data and o_dq_is_crc=0 at t+1.
  - CRC cycle t: o_dq_valid=1, o_dq_data=i_crc_code and o_dq_is_crc=1 at t+1.
REQ-026 No-accept cycles (other than the CRC cycle): o_dq_valid=0 and o_dq_is_crc=0 next cycle; o_dq_data holds its last value.
REQ-027 o_burst_done=1 together with the output of the CRC word (mode_q=1) or of data word 8 (mode_q=0); 0 otherwise.
REQ-028 Back-to-back bursts:
  - mode_q=0: a word may be accepted in the cycle right after the 8th, with no bubble.
  - mode_q=1: exactly one bubble input cycle (the CRC cycle) between bursts.
REQ-029 i_crc_mode changes during a burst have no effect until the next burst's first accept.
REQ-030 The CRC generator's 8-beat count relies on o_crc_en pulsing exactly 9 times per CRC-enabled burst and 8 times per CRC-disabled burst.

Reset
REQ-031 While i_reset=0 at a clock edge, the following SHALL hold after that edge:
  - state=IDLE, cnt=0, mode_q=0;
  - o_dq_valid=0, o_dq_is_crc=0, o_burst_done=0, o_dq_data=0;
  - any partial burst is discarded.
REQ-032 During reset, o_wr_ready=0 and o_crc_en=0, so no word is accepted.
REQ-033 The first cycle after reset release is IDLE with o_wr_ready=1.

Verification
REQ-034 N=16, crc_mode=1, words 0x00000001..0x00000008 on consecutive cycles, stub i_crc_code=0xA5A5A5A5 -> o_dq_data 0x1..0x8 on cycles 1..8, 0xA5A5A5A5 with o_dq_is_crc=1 and o_burst_done=1 on cycle 9, o_wr_ready=0 in input cycle 8.
REQ-035 crc_mode=0, two bursts fully back-to-back (16 words) -> 16 consecutive o_dq_valid, o_crc_en high 16 cycles, o_burst_done at outputs 8 and 16, never o_dq_is_crc.
REQ-036 crc_mode=1, i_wr_valid low for 3 cycles after word 4 -> cnt holds, o_crc_en low in gap cycles, CRC word still follows word 8 by one cycle, 9 total o_crc_en pulses.
REQ-037 i_crc_mode toggled 1->0 after word 2 -> CRC word still emitted for that burst; next burst has no CRC word.
REQ-038 Reset asserted after word 5, released, new 8-word burst -> no output during reset, new burst framed from word 1 with correct CRC cycle placement.
REQ-039 Upstream CRC generator integrated, N=4, all-zero data, crc_mode=1 -> CRC word 0x00, o_burst_done once.
